// File: rtl/comparator_core.sv
// Registered equality/magnitude comparator with a saturating match counter.
// Optional COMPARATOR_MASK_EN adds a per-bit mask port; masked-off bits are don't-care.
module comparator_core #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
`ifdef COMPARATOR_MASK_EN
  input  logic [WIDTH-1:0]     mask,
`endif
  input  logic                 clr_count,
  output logic                 out,
  output logic                 lt,
  output logic                 gt,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] match_count
);

  logic [WIDTH-1:0]     a_m;
  logic [WIDTH-1:0]     b_m;
  logic                 eq_next;
  logic                 lt_next;
  logic                 gt_next;
  logic                 eq_reg;
  logic                 lt_reg;
  logic                 gt_reg;
  logic                 valid_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic [CNT_WIDTH-1:0] count_next;

  // Masking both operands makes equality identical to ((in0 ^ in1) & mask) == 0.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask
`ifdef COMPARATOR_MASK_EN
      assign a_m[gi] = in0[gi] & mask[gi];
      assign b_m[gi] = in1[gi] & mask[gi];
`else
      assign a_m[gi] = in0[gi];
      assign b_m[gi] = in1[gi];
`endif
    end
  endgenerate

  assign eq_next = (a_m == b_m);
  assign lt_next = (a_m <  b_m);
  assign gt_next = (a_m >  b_m);

  always_comb begin
    count_next = count_reg;
    if (clr_count) begin
      count_next = '0;
    end else if (in_valid && eq_next && (count_reg != {CNT_WIDTH{1'b1}})) begin
      count_next = count_reg + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq_reg    <= 1'b0;
      lt_reg    <= 1'b0;
      gt_reg    <= 1'b0;
      valid_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      valid_reg <= in_valid;
      count_reg <= count_next;
      // Result flags hold across idle cycles; only out_valid drops.
      if (in_valid) begin
        eq_reg <= eq_next;
        lt_reg <= lt_next;
        gt_reg <= gt_next;
      end
    end
  end

  assign out         = eq_reg;
  assign lt          = lt_reg;
  assign gt          = gt_reg;
  assign out_valid   = valid_reg;
  assign match_count = count_reg;

endmodule

// File: tb/tb_comparator_core.sv
// Scoreboard bench for comparator_core: two instances (8-bit and 2-bit counters) share stimulus.
module tb_comparator_core;

  typedef struct {
    int         id;
    logic       o;
    logic       l;
    logic       g;
    logic       v;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in0;
  logic [3:0] in1;
  logic [3:0] mask;
  logic       clr_count;
  logic       out_a, lt_a, gt_a, ov_a;
  logic       out_b, lt_b, gt_b, ov_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  comparator_core #(.WIDTH(4), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in0(in0), .in1(in1),
`ifdef COMPARATOR_MASK_EN
    .mask(mask),
`endif
    .clr_count(clr_count), .out(out_a), .lt(lt_a), .gt(gt_a),
    .out_valid(ov_a), .match_count(cnt_a)
  );

  comparator_core #(.WIDTH(4), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in0(in0), .in1(in1),
`ifdef COMPARATOR_MASK_EN
    .mask(mask),
`endif
    .clr_count(clr_count), .out(out_b), .lt(lt_b), .gt(gt_b),
    .out_valid(ov_b), .match_count(cnt_b)
  );

  // Drive one cycle of stimulus and push the hand-computed response.
  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic clr, input logic [3:0] m,
                      input logic eo, input logic el, input logic eg, input logic ev,
                      input logic [7:0] e8, input logic [1:0] e2);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in0       = a;
    in1       = b;
    clr_count = clr;
    mask      = m;
    step_id++;
    e.id = step_id; e.o = eo; e.l = el; e.g = eg; e.v = ev; e.c8 = e8; e.c2 = e2;
    exp_q.push_back(e);
    $display("issue %0d: v=%0b in0=%0d in1=%0d clr=%0b mask=%h", step_id, v, a, b, clr, m);
  endtask

  task automatic check_now(input string name, input logic eo, input logic el, input logic eg,
                           input logic ev, input logic [7:0] e8, input logic [1:0] e2);
    logic [16:0] act, req;
    act = {out_a, lt_a, gt_a, ov_a, cnt_a, out_b, lt_b, gt_b, ov_b, cnt_b};
    req = {eo, el, eg, ev, e8, eo, el, eg, ev, e2};
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got a:o=%0b l=%0b g=%0b v=%0b c=%0d b:o=%0b l=%0b g=%0b v=%0b c=%0d want o=%0b l=%0b g=%0b v=%0b c8=%0d c2=%0d",
               name, out_a, lt_a, gt_a, ov_a, cnt_a, out_b, lt_b, gt_b, ov_b, cnt_b,
               eo, el, eg, ev, e8, e2);
    end else begin
      $display("ok %s: o=%0b l=%0b g=%0b v=%0b c8=%0d c2=%0d", name, out_a, lt_a, gt_a, ov_a, cnt_a, cnt_b);
    end
  endtask

  // Monitor: results appear one edge after issue; sample 1 time unit past the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now($sformatf("step%0d", e.id), e.o, e.l, e.g, e.v, e.c8, e.c2);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; clr_count = 1'b0; mask = 4'hF;
    #2;
    check_now("reset", 0, 0, 0, 0, 8'd0, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    //    v  in0    in1    clr mask   o  l  g  v  c8     c2
    step(1, 4'd0,  4'd0,  0, 4'hF,  1, 0, 0, 1, 8'd1, 2'd1);
    step(1, 4'd1,  4'd2,  0, 4'hF,  0, 1, 0, 1, 8'd1, 2'd1);
    step(1, 4'd1,  4'd3,  0, 4'hF,  0, 1, 0, 1, 8'd1, 2'd1);
    step(1, 4'd3,  4'd1,  0, 4'hF,  0, 0, 1, 1, 8'd1, 2'd1);
    step(1, 4'd3,  4'd3,  0, 4'hF,  1, 0, 0, 1, 8'd2, 2'd2);
    step(1, 4'd7,  4'd7,  0, 4'hF,  1, 0, 0, 1, 8'd3, 2'd3);
    step(0, 4'd5,  4'd9,  0, 4'hF,  1, 0, 0, 0, 8'd3, 2'd3);
    step(1, 4'd15, 4'd0,  0, 4'hF,  0, 0, 1, 1, 8'd3, 2'd3);
    step(1, 4'd0,  4'd15, 0, 4'hF,  0, 1, 0, 1, 8'd3, 2'd3);
    step(0, 4'd4,  4'd4,  1, 4'hF,  0, 1, 0, 0, 8'd0, 2'd0);
    // Saturation run on the 2-bit counter.
    step(1, 4'd1,  4'd1,  0, 4'hF,  1, 0, 0, 1, 8'd1, 2'd1);
    step(1, 4'd2,  4'd2,  0, 4'hF,  1, 0, 0, 1, 8'd2, 2'd2);
    step(1, 4'd4,  4'd4,  0, 4'hF,  1, 0, 0, 1, 8'd3, 2'd3);
    step(1, 4'd8,  4'd8,  0, 4'hF,  1, 0, 0, 1, 8'd4, 2'd3);
    step(1, 4'd6,  4'd6,  0, 4'hF,  1, 0, 0, 1, 8'd5, 2'd3);
    step(1, 4'd9,  4'd9,  1, 4'hF,  1, 0, 0, 1, 8'd0, 2'd0);
    step(1, 4'd14, 4'd15, 0, 4'hF,  0, 1, 0, 1, 8'd0, 2'd0);
    step(1, 4'd15, 4'd15, 0, 4'hF,  1, 0, 0, 1, 8'd1, 2'd1);

    // Asynchronous reset between edges clears everything at once.
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    clr_count = 1'b0;
    #1;
    check_now("midreset", 0, 0, 0, 0, 8'd0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 4'd0,  4'd0,  0, 4'hF,  1, 0, 0, 1, 8'd1, 2'd1);
`ifdef COMPARATOR_MASK_EN
    step(1, 4'b1101, 4'b0001, 0, 4'b0011, 1, 0, 0, 1, 8'd2, 2'd2);
    step(1, 4'b1101, 4'b0001, 0, 4'b1111, 0, 0, 1, 1, 8'd2, 2'd2);
    step(1, 4'b1000, 4'b0100, 0, 4'b0011, 1, 0, 0, 1, 8'd3, 2'd3);
`endif
    step(0, 4'd0,  4'd0,  0, 4'hF,  1, 0, 0, 0,
`ifdef COMPARATOR_MASK_EN
         8'd3, 2'd3);
`else
         8'd1, 2'd1);
`endif

    repeat (4) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
